// File: rtl/tpmem_ctrl_if.sv
// Row-input, TPmem-side and column-output signals of the transpose-memory
// controller. The controller connects through the master modport; the
// environment (upstream row stage, TPmem, column consumer) uses slave.
interface tpmem_ctrl_if #(
  parameter int BW = 11
);
  // Upstream row stage
  logic              i_row_valid;
  logic              o_row_ready;
  logic [16*BW-1:0]  i_row_data;
  // TPmem
  logic [16*BW-1:0]  o_tp_data;
  logic              o_tp_enable;
  logic              o_tp_rst_n;
  logic              i_tp_en;
  // Column framing
  logic              o_col_valid;
  logic [3:0]        o_col_idx;
  logic              o_col_last;
  logic              o_blk_last;

  modport master (
    input  i_row_valid, i_row_data, i_tp_en,
    output o_row_ready, o_tp_data, o_tp_enable, o_tp_rst_n,
           o_col_valid, o_col_idx, o_col_last, o_blk_last
  );

  modport slave (
    output i_row_valid, i_row_data, i_tp_en,
    input  o_row_ready, o_tp_data, o_tp_enable, o_tp_rst_n,
           o_col_valid, o_col_idx, o_col_last, o_blk_last
  );
endinterface

// File: rtl/tpmem_ctrl.sv
// Sequencer for the 16x16 transpose memory between the row and column
// passes: loads 16 rows per block, holds off upstream during the 16-cycle
// column drain, frames the column beats and flags any deviation of the
// TPmem output-enable from the expected schedule.
module tpmem_ctrl #(
  parameter int BW    = 11,
  parameter int BLK_W = 8
) (
  input  logic             i_clk,
  input  logic             i_Reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [BLK_W-1:0] i_num_blk,
  tpmem_ctrl_if.master     bus,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_err
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [3:0]       row_cnt_q, row_cnt_d;
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic [3:0]       col_idx_q, col_idx_d;
  logic [BLK_W-1:0] num_blk_q, num_blk_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [BLK_W-1:0] out_blk_q, out_blk_d;
  logic             post_drain_q, post_drain_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             tp_rst_n_q, tp_rst_n_d;
  logic             rst_done_q;

  logic             abort_act;
  logic             row_acc;
  logic             exp_en;
  logic [16*BW-1:0] row_word;

  // Abort only matters once a frame is running; in IDLE it just masks i_start.
  assign abort_act = i_abort && (state_q != IDLE);
  // Ready is high for the whole of LOAD, so a beat is accepted on valid alone.
  assign row_acc   = (state_q == LOAD) && bus.i_row_valid;
  // TPmem emits its 16 columns on drain cycles 1..15 plus the cycle after.
  assign exp_en    = ((state_q == DRAIN) && (drain_cnt_q != 4'd0)) || post_drain_q;
  assign row_word  = bus.i_row_data;

  // Next-state, counter and flag logic.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    col_idx_d    = col_idx_q;
    num_blk_d    = num_blk_q;
    blk_cnt_d    = blk_cnt_q;
    out_blk_d    = out_blk_q;
    post_drain_d = 1'b0;
    err_d        = err_q;
    done_d       = 1'b0;
    tp_rst_n_d   = rst_done_q;

    // The cycle in which TPmem is being reset is not compared: its o_en
    // there still reflects the pre-reset counter.
    if (tp_rst_n_q && (bus.i_tp_en != exp_en)) begin
      err_d = 1'b1;
    end

    if (bus.i_tp_en) begin
      col_idx_d = col_idx_q + 4'd1;
      if (col_idx_q == 4'd15) begin
        out_blk_d = out_blk_q + BLK_W'(1);
      end
    end

    if (abort_act) begin
      state_d     = IDLE;
      row_cnt_d   = '0;
      drain_cnt_d = '0;
      col_idx_d   = '0;
      blk_cnt_d   = '0;
      out_blk_d   = '0;
      tp_rst_n_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start && !i_abort) begin
            if (i_num_blk != '0) begin
              num_blk_d   = i_num_blk;
              err_d       = 1'b0;
              row_cnt_d   = '0;
              drain_cnt_d = '0;
              col_idx_d   = '0;
              blk_cnt_d   = '0;
              out_blk_d   = '0;
              state_d     = LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        LOAD: begin
          if (row_acc) begin
            row_cnt_d = row_cnt_q + 4'd1;
            if (row_cnt_q == 4'd15) begin
              drain_cnt_d = '0;
              state_d     = DRAIN;
            end
          end
        end
        DRAIN: begin
          drain_cnt_d = drain_cnt_q + 4'd1;
          if (drain_cnt_q == 4'd15) begin
            post_drain_d = 1'b1;
            blk_cnt_d    = blk_cnt_q + BLK_W'(1);
            if ((blk_cnt_q + BLK_W'(1)) == num_blk_q) begin
              state_d = FLUSH;
            end else begin
              row_cnt_d = '0;
              state_d   = LOAD;
            end
          end
        end
        FLUSH: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers; TPmem reset is held low one full cycle out of reset.
  always_ff @(posedge i_clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      row_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      col_idx_q    <= '0;
      num_blk_q    <= '0;
      blk_cnt_q    <= '0;
      out_blk_q    <= '0;
      post_drain_q <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      tp_rst_n_q   <= 1'b0;
      rst_done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      col_idx_q    <= col_idx_d;
      num_blk_q    <= num_blk_d;
      blk_cnt_q    <= blk_cnt_d;
      out_blk_q    <= out_blk_d;
      post_drain_q <= post_drain_d;
      err_q        <= err_d;
      done_q       <= done_d;
      tp_rst_n_q   <= tp_rst_n_d;
      rst_done_q   <= 1'b1;
    end
  end

  assign bus.o_row_ready = (state_q == LOAD);
  assign bus.o_tp_enable = row_acc;
  assign bus.o_tp_data   = row_word;
  assign bus.o_tp_rst_n  = tp_rst_n_q;
  assign bus.o_col_valid = bus.i_tp_en;
  assign bus.o_col_idx   = col_idx_q;
  assign bus.o_col_last  = bus.i_tp_en && (col_idx_q == 4'd15);
  assign bus.o_blk_last  = (state_q != IDLE) && (out_blk_q == (num_blk_q - BLK_W'(1)));
  assign o_busy          = (state_q != IDLE);
  assign o_frame_done    = done_q;
  assign o_err           = err_q;

endmodule
